// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types and constants for the M:SS BCD countdown timer.
package countdown_pkg;

  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  DSEC_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A keyed digit is accepted only if it is BCD and the seconds digit can
  // legally move into the tens-of-seconds position.
  function automatic logic entry_ok(input logic [BCD_W-1:0] digit_in,
                                    input logic [BCD_W-1:0] sec_cur);
    return (digit_in <= BCD_MAX) && (sec_cur <= DSEC_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Control/strobe and display bundle of the countdown timer.
interface countdown_timer_bcd_if;
  import countdown_pkg::*;

  // Every input is a 1-cycle strobe sampled on each rising clock edge; there
  // is no ready/backpressure, so a strobe is consumed in the cycle it is high.
  logic             tick_in;
  logic [BCD_W-1:0] digit_in;
  logic             digit_valid;
  logic             start;
  logic             stop;
  logic             clear;
  logic [BCD_W-1:0] min;
  logic [BCD_W-1:0] dsec;
  logic [BCD_W-1:0] sec;
  logic             running;
  logic             done;
  logic             alarm;
  logic [1:0]       state_dbg;

  modport master (
    output tick_in, digit_in, digit_valid, start, stop, clear,
    input  min, dsec, sec, running, done, alarm, state_dbg
  );

  modport slave (
    input  tick_in, digit_in, digit_valid, start, stop, clear,
    output min, dsec, sec, running, done, alarm, state_dbg
  );

endinterface

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD digit of a borrow-chained down counter (wraps 0 -> max_i).
module bcd_digit_down
  import countdown_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic [BCD_W-1:0] max_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (dec_i) begin
      if (digit_i == '0) begin
        digit_o  = max_i;
        borrow_o = 1'b1;
      end else begin
        digit_o  = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// M:SS BCD countdown timer with keypad shift entry.
// Build option: define COUNTDOWN_PRESCALER_EN to derive the tick internally.
module countdown_timer_bcd
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  countdown_timer_bcd_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [BCD_W-1:0] min_q, min_d;
  logic [BCD_W-1:0] dsec_q, dsec_d;
  logic [BCD_W-1:0] sec_q, sec_d;
  logic             done_q, done_d;
  logic             running_q, alarm_q;
  logic             tick;

`ifdef COUNTDOWN_PRESCALER_EN
  logic [DIV_W-1:0] div_q, div_d;
  logic             unused_tick_in;

  assign unused_tick_in = bus.tick_in;
  assign tick = (state_q == S_RUN) && (div_q == DIV_W'(TICK_DIV - 1));

  // Restarting at zero on RUN entry puts the first decrement TICK_DIV cycles after start.
  always_comb begin
    div_d = div_q;
    if (bus.clear) begin
      div_d = '0;
    end else if ((state_q != S_RUN) && (state_d == S_RUN)) begin
      div_d = '0;
    end else if (state_q == S_RUN) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{TICK_DIV[0], DIV_W[0]};
  assign tick       = bus.tick_in;
`endif

  logic [BCD_W-1:0] sec_nxt, dsec_nxt, min_nxt;
  logic             sec_borrow, dsec_borrow, unused_min_borrow;
  logic             nxt_zero, time_zero;

  bcd_digit_down u_sec (
    .digit_i (sec_q),
    .max_i   (BCD_MAX),
    .dec_i   (tick),
    .digit_o (sec_nxt),
    .borrow_o(sec_borrow)
  );

  bcd_digit_down u_dsec (
    .digit_i (dsec_q),
    .max_i   (DSEC_MAX),
    .dec_i   (sec_borrow),
    .digit_o (dsec_nxt),
    .borrow_o(dsec_borrow)
  );

  bcd_digit_down u_min (
    .digit_i (min_q),
    .max_i   (BCD_MAX),
    .dec_i   (dsec_borrow),
    .digit_o (min_nxt),
    .borrow_o(unused_min_borrow)
  );

  assign time_zero = (min_q == '0) && (dsec_q == '0) && (sec_q == '0);
  assign nxt_zero  = (min_nxt == '0) && (dsec_nxt == '0) && (sec_nxt == '0);

  // Priority: clear > stop > start > tick > digit_valid.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    dsec_d  = dsec_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = S_IDLE;
      min_d   = '0;
      dsec_d  = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !time_zero) begin
            state_d = S_RUN;
          end else if (bus.digit_valid && entry_ok(bus.digit_in, sec_q)) begin
            min_d  = dsec_q;
            dsec_d = sec_q;
            sec_d  = bus.digit_in;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            min_d  = min_nxt;
            dsec_d = dsec_nxt;
            sec_d  = sec_nxt;
            if (nxt_zero) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (bus.start) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      dsec_q    <= '0;
      sec_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      dsec_q    <= dsec_d;
      sec_q     <= sec_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_DONE);
    end
  end

  assign bus.min       = min_q;
  assign bus.dsec      = dsec_q;
  assign bus.sec       = sec_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.alarm     = alarm_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Randomised bench for countdown_timer_bcd against a seconds-based reference model.
module tb_countdown_timer_bcd;

`ifdef COUNTDOWN_PRESCALER_EN
  localparam int TDIV = 4;
`else
  localparam int TDIV = 50_000_000;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  countdown_timer_bcd_if bus();

  countdown_timer_bcd #(.TICK_DIV(TDIV), .DIV_W(26)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  int m_state = M_IDLE;
  int m_secs  = 0;
  int m_cnt   = 0;
  bit m_done  = 1'b0;

  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] pack_exp();
    logic [3:0] mi, ds, se;
    mi = 4'(m_secs / 60);
    ds = 4'((m_secs % 60) / 10);
    se = 4'(m_secs % 10);
    return {mi, ds, se, (m_state == M_RUN), m_done, (m_state == M_DONE)};
  endfunction

  // Time is kept as total seconds; digits are only derived for comparison.
  task automatic model_step(input bit clr, input bit stp, input bit sta,
                            input bit tck, input bit dv, input int din);
    int old_state;
    bit t;
    old_state = m_state;
`ifdef COUNTDOWN_PRESCALER_EN
    t = (m_state == M_RUN) && (m_cnt == TDIV - 1);
`else
    t = tck;
`endif
    m_done = 1'b0;
    if (clr) begin
      m_state = M_IDLE;
      m_secs  = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (sta && m_secs != 0) m_state = M_RUN;
          else if (dv && din <= 9 && (m_secs % 10) <= 5)
            m_secs = ((m_secs % 60) / 10) * 60 + (m_secs % 10) * 10 + din;
        end
        M_RUN: begin
          if (stp) m_state = M_PAUSE;
          else if (t) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
              m_state = M_DONE;
              m_done  = 1'b1;
            end
          end
        end
        M_PAUSE: if (sta) m_state = M_RUN;
        default: ;
      endcase
    end
    if (clr) m_cnt = 0;
    else if (old_state != M_RUN && m_state == M_RUN) m_cnt = 0;
    else if (old_state == M_RUN) m_cnt = t ? 0 : m_cnt + 1;
  endtask

  task automatic step(input bit clr, input bit stp, input bit sta,
                      input bit tck, input bit dv, input logic [3:0] din);
    logic [14:0] e;
    bus.clear       = clr;
    bus.stop        = stp;
    bus.start       = sta;
    bus.tick_in     = tck;
    bus.digit_valid = dv;
    bus.digit_in    = din;
    @(posedge clk);
    model_step(clr, stp, sta, tck, dv, int'(din));
    exp_q.push_back(pack_exp());
    #1;
    e = exp_q.pop_front();
    check("min",     32'(bus.min),     32'(e[14:11]));
    check("dsec",    32'(bus.dsec),    32'(e[10:7]));
    check("sec",     32'(bus.sec),     32'(e[6:3]));
    check("running", 32'(bus.running), 32'(e[2]));
    check("done",    32'(bus.done),    32'(e[1]));
    check("alarm",   32'(bus.alarm),   32'(e[0]));
  endtask

  task automatic key(input logic [3:0] d);  step(0, 0, 0, 0, 1, d);    endtask
  task automatic tick();                    step(0, 0, 0, 1, 0, 4'd0); endtask
  task automatic idle();                    step(0, 0, 0, 0, 0, 4'd0); endtask
  task automatic do_start();                step(0, 0, 1, 0, 0, 4'd0); endtask
  task automatic do_clear();                step(1, 0, 0, 0, 0, 4'd0); endtask

  initial begin
    bus.clear = 0; bus.stop = 0; bus.start = 0;
    bus.tick_in = 0; bus.digit_valid = 0; bus.digit_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits",  32'({bus.min, bus.dsec, bus.sec}), 32'h000);
    check("rst_flags",   32'({bus.running, bus.done, bus.alarm}), 32'h0);
    rst_n = 1'b1;

    // Keypad entry and rejection of an entry that would break dsec.
    key(4'd1); key(4'd3); key(4'd0);
    check("key130", 32'({bus.min, bus.dsec, bus.sec}), 32'h130);
    key(4'd7);
    check("key307", 32'({bus.min, bus.dsec, bus.sec}), 32'h307);
    key(4'd2);
    check("key_rej", 32'({bus.min, bus.dsec, bus.sec}), 32'h307);
    do_clear();
    key(4'd11);
    check("key_bad", 32'({bus.min, bus.dsec, bus.sec}), 32'h000);

    // 1:00 down to 0:00.
    key(4'd1); key(4'd0); key(4'd0);
    do_start();
    tick();
`ifndef COUNTDOWN_PRESCALER_EN
    check("borrow_059", 32'({bus.min, bus.dsec, bus.sec}), 32'h059);
`endif
    repeat (59) tick();
`ifdef COUNTDOWN_PRESCALER_EN
    repeat (240) idle();
`endif
    idle();
    do_start();
    idle();
    do_clear();

    // Pause/resume with tick coinciding with stop.
    key(4'd5);
    do_start();
    tick(); tick();
    step(0, 1, 0, 1, 0, 4'd0);
    tick(); tick(); tick();
    do_start();
    tick();
    do_clear();

    // start at 0:00 is ignored.
    do_start();
    idle();

    // clear beats start and tick at 2:10.
    key(4'd2); key(4'd1); key(4'd0);
    do_start();
    step(1, 0, 1, 1, 0, 4'd0);
    idle();

`ifdef COUNTDOWN_PRESCALER_EN
    // Internal prescaler: tick_in toggling must not matter.
    key(4'd2);
    do_start();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1'($urandom_range(0, 1)), 0, 4'd0);
    do_clear();
`endif

    // Random traffic; short keyed times keep DONE reachable.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 11)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
